// File: rtl/spi_slave_single_port_ram.sv
// SPI slave front-end around a single-port synchronous RAM.
// Each frame is an op bit followed by a 10-bit word (2-bit command and 8-bit payload), MSB first.
// Commands: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
// A read-data command returns the addressed byte on MISO, MSB first.

module spi_slave_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_din,
  input  logic       i_rx_valid,
  output logic [7:0] o_dout,
  output logic       o_tx_valid
);

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [7:0]           r_dout;
  logic                 r_tx_valid;

  // Address registers, read port and the one-cycle tx_valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      if (i_rx_valid) begin
        case (i_din[9:8])
          2'b00:   r_wr_addr <= ADDR_SIZE'(i_din[7:0]);
          2'b10:   r_rd_addr <= ADDR_SIZE'(i_din[7:0]);
          2'b11: begin
            r_dout     <= mem[r_rd_addr];
            r_tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage write port.
  // NOTE: the array sits in its own reset-free block so it maps onto RAM macros; resetting it would force flops.
  always_ff @(posedge clk) begin
    if (i_rx_valid && i_din[9:8] == 2'b01) begin
      mem[r_wr_addr] <= i_din[7:0];
    end
  end

  assign o_dout     = r_dout;
  assign o_tx_valid = r_tx_valid;

endmodule

module spi_slave_single_port_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_bit_cnt;
  logic [9:0]  r_rx_shift;
  logic        r_rx_valid;
  logic        r_rd_addr_flag;
  logic [7:0]  r_tx_shift;
  logic [3:0]  r_tx_cnt;
  logic        r_tx_active;
  logic        r_miso;
  logic [7:0]  w_dout;
  logic        w_tx_valid;
  logic        w_tx_done;

  spi_slave_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) ram (
    .clk        (clk),
    .rst        (rst),
    .i_din      (r_rx_shift),
    .i_rx_valid (r_rx_valid),
    .o_dout     (w_dout),
    .o_tx_valid (w_tx_valid)
  );

  // State register.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode; SS_n high from any state returns to IDLE.
  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_next_state = r_state;
    if (SS_n) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)               w_next_state = WRITE;
          else if (r_rd_addr_flag) w_next_state = READ_DATA;
          else                     w_next_state = READ_ADD;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  // Receive shifter: 10 bits after the op bit, then ignore MOSI until SS_n rises.
  always_ff @(posedge clk) begin
    if (rst || SS_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == CHK_CMD) begin
        r_bit_cnt <= '0;
      end else if (r_state inside {WRITE, READ_ADD, READ_DATA} && r_bit_cnt != 4'd10) begin
        r_rx_shift <= {r_rx_shift[8:0], MOSI};
        r_bit_cnt  <= r_bit_cnt + 4'd1;
        if (r_bit_cnt == 4'd9) r_rx_valid <= 1'b1;
      end
    end
  end

  // The transmit sequence ends on the edge that returns MISO to 0 after bit 0.
  assign w_tx_done = !SS_n && r_tx_active && !w_tx_valid && (r_tx_cnt == 4'd0);

  // Transmit serialiser: load on tx_valid, then eight MSB-first bits, then idle low.
  always_ff @(posedge clk) begin
    if (rst || SS_n) begin
      r_tx_shift  <= '0;
      r_tx_cnt    <= '0;
      r_tx_active <= 1'b0;
      r_miso      <= 1'b0;
    end else if (w_tx_valid) begin
      r_tx_shift  <= w_dout;
      r_tx_cnt    <= 4'd8;
      r_tx_active <= 1'b1;
      r_miso      <= 1'b0;
    end else if (r_tx_active) begin
      if (r_tx_cnt != 4'd0) begin
        r_miso     <= r_tx_shift[7];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        r_tx_cnt   <= r_tx_cnt - 4'd1;
      end else begin
        r_miso      <= 1'b0;
        r_tx_active <= 1'b0;
      end
    end
  end

  // Read-address flag: set by a read-address word, cleared once a read byte has fully gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr_flag <= 1'b0;
    end else if (r_rx_valid && r_rx_shift[9:8] == 2'b10) begin
      r_rd_addr_flag <= 1'b1;
    end else if (w_tx_done) begin
      r_rd_addr_flag <= 1'b0;
    end
  end

  assign MISO = r_miso;

endmodule

// File: tb/tb_spi_slave_single_port_ram.sv
// Self-checking bench for spi_slave_single_port_ram: directed test-plan steps followed by
// random frames, all compared against a byte-array memory model with address/flag variables.

module tb_spi_slave_single_port_ram;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [7:0] model_mem [256];
  logic [7:0] model_wr_addr;
  logic [7:0] model_rd_addr;
  logic       model_flag;

  spi_slave_single_port_ram #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame. For read-data, reads up to stop_bits MISO bits (8 = complete byte);
  // fewer than 8 aborts the transmit by raising SS_n.
  task automatic send_frame(input logic op, input logic [1:0] cmd, input logic [7:0] payload,
                            input int stop_bits);
    logic [9:0] word;
    logic [7:0] exp_byte;
    word = {cmd, payload};
    @(negedge clk); SS_n = 1'b0; MOSI = 1'($urandom);
    @(negedge clk); MOSI = op;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk); MOSI = word[i];
    end
    @(negedge clk); MOSI = 1'($urandom);
    if (cmd == 2'b11) begin
      exp_byte = model_mem[model_rd_addr];
      @(negedge clk);
      @(negedge clk);
      check("miso_before_tx", 16'(MISO), 16'd0);
      for (int b = 7; b >= 8 - stop_bits; b--) begin
        @(negedge clk); MOSI = 1'($urandom);
        check($sformatf("miso_bit%0d", b), 16'(MISO), 16'(exp_byte[b]));
      end
      if (stop_bits >= 8) begin
        @(negedge clk);
        check("miso_after_tx", 16'(MISO), 16'd0);
        model_flag = 1'b0;
      end else begin
        SS_n = 1'b1;
        @(negedge clk);
        check("miso_abort", 16'(MISO), 16'd0);
      end
    end else begin
      @(negedge clk);
      case (cmd)
        2'b00: begin
          model_wr_addr = payload;
          check("wr_addr", 16'(dut.ram.r_wr_addr), 16'(model_wr_addr));
        end
        2'b01: begin
          model_mem[model_wr_addr] = payload;
          check("mem_write", 16'(dut.ram.mem[model_wr_addr]), 16'(payload));
        end
        default: begin
          model_rd_addr = payload;
          model_flag    = 1'b1;
          check("rd_addr", 16'(dut.ram.r_rd_addr), 16'(model_rd_addr));
        end
      endcase
    end
    SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("miso_idle", 16'(MISO), 16'd0);
    check("rd_flag", 16'(dut.r_rd_addr_flag), 16'(model_flag));
  endtask

  initial begin
    logic [9:0] word;
    logic       seen_rx;
    logic [1:0] rcmd;
    logic [7:0] rpay;

    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i]   = 8'($urandom);
      dut.ram.mem[i] = model_mem[i];
    end
    model_wr_addr = '0; model_rd_addr = '0; model_flag = 1'b0;

    // Reset for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("reset_miso", 16'(MISO), 16'd0);
    check("reset_flag", 16'(dut.r_rd_addr_flag), 16'd0);
    check("reset_rx_valid", 16'(dut.r_rx_valid), 16'd0);
    check("reset_mem", 16'(dut.ram.mem[8'h10]), 16'(model_mem[8'h10]));
    rst = 1'b0;
    @(negedge clk);

    // Write-address 0xFF, write-data 0xA5.
    send_frame(1'b0, 2'b00, 8'hFF, 8);
    check("mem_untouched", 16'(dut.ram.mem[8'hFF]), 16'(model_mem[8'hFF]));
    send_frame(1'b0, 2'b01, 8'hA5, 8);
    check("mem_ff_a5", 16'(dut.ram.mem[8'hFF]), 16'h00A5);

    // Read-address 0xFF then read-data: 1,0,1,0,0,1,0,1 on MISO.
    send_frame(1'b1, 2'b10, 8'hFF, 8);
    send_frame(1'b1, 2'b11, 8'($urandom), 8);

    // Preloaded read of 0x3C at 0x10.
    dut.ram.mem[8'h10] = 8'h3C;
    model_mem[8'h10]   = 8'h3C;
    send_frame(1'b1, 2'b10, 8'h10, 8);
    send_frame(1'b1, 2'b11, 8'h00, 8);

    // Abort a write-data frame after 5 payload bits.
    word = 10'b01_0000_0000;
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = 1'b0;
    for (int i = 9; i >= 3; i--) begin
      @(negedge clk); MOSI = word[i];
    end
    @(negedge clk); SS_n = 1'b1; MOSI = 1'b1;
    seen_rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_rx = seen_rx | dut.r_rx_valid;
    end
    check("abort_rx_valid", 16'(seen_rx), 16'd0);
    check("abort_mem", 16'(dut.ram.mem[8'hFF]), 16'(model_mem[8'hFF]));
    check("abort_miso", 16'(MISO), 16'd0);

    // A full frame after the abort must start from a clean counter.
    send_frame(1'b0, 2'b01, 8'h5A, 8);

    // Abort mid-transmit after three bits; flag stays set, a full read follows.
    send_frame(1'b1, 2'b10, 8'h10, 8);
    send_frame(1'b1, 2'b11, 8'h00, 3);
    send_frame(1'b1, 2'b11, 8'h00, 8);

    // Randomised frames, including op-bit/command mismatches.
    for (int n = 0; n < 60; n++) begin
      rcmd = 2'($urandom);
      rpay = 8'($urandom_range(0, 15));
      send_frame(1'($urandom), rcmd, rpay, 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_single_port_ram.md
Name: spi_slave_single_port_ram

Overview:
SPI slave front-end wrapped around a single-port synchronous RAM. It deserialises 10-bit MOSI words, each a 2-bit command plus 8-bit payload, and passes them to the RAM. Supported commands are write-address, write-data, read-address and read-data. For read-data, the addressed byte is serialised back on MISO. The block sits at the top of a simple SPI-accessible memory; the RAM is an internal sub-instance.

Parameters:
MEM_DEPTH, 256, number of RAM words.
ADDR_SIZE, 8, RAM address width (log2 MEM_DEPTH).

Ports:
clk  input  1  system clock; all logic on rising edge; SPI bits sampled one per clk.
rst  input  1  synchronous, active-high reset.
SS_n  input  1  slave select, active low; high aborts or ends a frame.
MOSI  input  1  serial data in, MSB first.
MISO  output  1  serial data out, MSB first.

Behaviour:
- Structure:
  - SPI FSM/shifter, plus an internal RAM instance named ram.
  - RAM array is named mem, 8 bits wide, MEM_DEPTH words, so benches may preload it hierarchically (ram.mem).
- Reset (rst=1 at clk edge):
  - FSM to IDLE; MISO=0.
  - Bit counter, shift registers, rx_valid, tx_valid, read-address-received flag, wr_addr and rd_addr all cleared.
  - mem is not reset.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - Any state with SS_n=1 -> IDLE next edge; counters clear, partial word discarded, MISO=0.
  - IDLE, SS_n=0 -> CHK_CMD.
  - CHK_CMD samples MOSI as the op bit; this bit is not stored. MOSI=0 -> WRITE. MOSI=1 -> READ_DATA if read-address flag set, else READ_ADD.
  - WRITE/READ_ADD/READ_DATA shift MOSI into a 10-bit register, one bit per clk, MSB first. Bits [9:8] = command, [7:0] = payload.
  - On the edge capturing bit 10, rx_data is complete and rx_valid goes high for exactly one cycle. Further MOSI bits are ignored until SS_n rises.
- RAM, acting on the edge where rx_valid=1, by rx_data[9:8]:
  - 00: wr_addr <= payload.
  - 01: mem[wr_addr] <= payload.
  - 10: rd_addr <= payload; slave sets read-address flag.
  - 11: dout <= mem[rd_addr]; tx_valid=1 for one cycle.
- Read-data transmit:
  - On the edge where tx_valid=1, load dout into the transmit register.
  - On the following 8 edges, drive MISO registered with bits 7..0.
  - MISO returns to 0 after bit 0; read-address flag clears.
  - Payload of a read-data command is don't-care.
- MISO is 0 whenever not transmitting.
- Command/op-bit mismatch: RAM obeys rx_data[9:8] regardless of the CHK_CMD path.
- Write-data before any write-address uses wr_addr=0.
- Addresses are ADDR_SIZE bits, so no out-of-range access is possible.
- SS_n rising mid-transmit aborts MISO immediately (0 next edge); the flag stays set.
- Back-to-back frames need at least one cycle of SS_n=1.

Test Plan:
- Reset: rst=1, SS_n=1 for 2 cycles -> MISO=0, FSM IDLE, no mem change.
- Write address: SS_n=0; op 0 in CHK_CMD; shift 00_11111111; SS_n=1 -> wr_addr=0xFF, mem unchanged.
- Write data: SS_n=0; op 0; shift 01_10100101 -> mem[0xFF]=0xA5 one cycle after rx_valid.
- Read address then data:
  - SS_n=0; op 1; shift 10_11111111 -> rd_addr=0xFF, flag set.
  - Next frame: op 1 enters READ_DATA; shift 11_xxxxxxxx -> MISO=1,0,1,0,0,1,0,1 on 8 consecutive cycles beginning 2 edges after rx_valid; flag cleared afterwards.
- Preloaded read: preload ram.mem[0x10]=0x3C; read-address 0x10 then read-data -> MISO serialises 0x3C MSB first.
- Abort: SS_n=1 after 5 payload bits of a write-data frame -> FSM IDLE next edge, no rx_valid, mem unchanged.
